// File: rtl/fifo_reader_if.sv
// Handshake bundle for fifo_reader: command port, upstream FIFO read port, downstream stream.
// The master side drives commands, upstream FIFO status/data and downstream ready.
interface fifo_reader_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int LEN_W      = 8
);
    logic                  cmd_start;
    logic [LEN_W-1:0]      cmd_len;
    logic                  cmd_busy;
    logic                  cmd_done;
    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_data_out;
    logic                  fifo_rd_en;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;

    modport master (
        output cmd_start, cmd_len, fifo_empty, fifo_data_out, m_ready,
        input  cmd_busy, cmd_done, fifo_rd_en, m_data, m_valid
    );

    modport slave (
        input  cmd_start, cmd_len, fifo_empty, fifo_data_out, m_ready,
        output cmd_busy, cmd_done, fifo_rd_en, m_data, m_valid
    );
endinterface

// File: rtl/fifo_reader.sv
// Burst reader: pulls cmd_len words from a registered-output FIFO into a 3-entry skid buffer
// feeding a valid/ready stream. Optional counters words_read/stall_cycles under FIFO_READER_STATS_EN.
module fifo_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int LEN_W      = 8
) (
    input  logic         clk,
    input  logic         rst,
    fifo_reader_if.slave bus
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [15:0]  words_read,
    output logic [15:0]  stall_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic [LEN_W-1:0]      remaining_q, remaining_d;
    logic                  inflight_q;
    logic [1:0]            occ_q, occ_d;
    logic [1:0]            rd_ptr_q, rd_ptr_d;
    logic [1:0]            wr_ptr_q, wr_ptr_d;
    logic [FIFO_WIDTH-1:0] mem_q [3];

    logic rd_en_s;
    logic push_s;
    logic pop_s;
    logic accept_s;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        if (p == 2'd2) begin
            ptr_inc = 2'd0;
        end else begin
            ptr_inc = p + 2'd1;
        end
    endfunction

    // Reads are throttled so buffered plus in-flight words never exceed the 3 buffer slots.
    assign rd_en_s  = (state_q == ST_BURST) && !bus.fifo_empty && (remaining_q != LEN_ZERO)
                      && (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
    assign push_s   = inflight_q;
    assign pop_s    = (occ_q != 2'd0) && bus.m_ready;
    assign accept_s = (state_q == ST_IDLE) && bus.cmd_start;

    // Next-state, remaining-count and buffer bookkeeping.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        occ_d       = occ_q;
        rd_ptr_d    = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d    = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_start) begin
                    remaining_d = bus.cmd_len;
                    state_d     = (bus.cmd_len == LEN_ZERO) ? ST_DONE : ST_BURST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (rd_en_s) begin
                    remaining_d = remaining_q - LEN_ONE;
                end else begin
                    remaining_d = remaining_q;
                end
                if (rd_en_s && (remaining_q == LEN_ONE)) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_BURST;
                end
            end
            ST_FLUSH: begin
                if (!inflight_q && (occ_q == 2'd0)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        case ({push_s, pop_s})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= LEN_ZERO;
            inflight_q  <= 1'b0;
            occ_q       <= 2'd0;
            rd_ptr_q    <= 2'd0;
            wr_ptr_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            inflight_q  <= rd_en_s;
            occ_q       <= occ_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
        end
    end

    // Skid buffer storage; the word arriving from the FIFO lands at the write pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= {FIFO_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= bus.fifo_data_out;
        end
    end

    assign bus.cmd_busy   = (state_q != ST_IDLE);
    assign bus.cmd_done   = (state_q == ST_DONE);
    assign bus.fifo_rd_en = rd_en_s;
    assign bus.m_valid    = (occ_q != 2'd0);
    assign bus.m_data     = mem_q[rd_ptr_q];

`ifdef FIFO_READER_STATS_EN
    logic [15:0] words_read_q;
    logic [15:0] stall_cycles_q;

    // Transfer counter wraps; stall counter saturates.
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            words_read_q   <= 16'd0;
            stall_cycles_q <= 16'd0;
        end else begin
            if (pop_s) begin
                words_read_q <= words_read_q + 16'd1;
            end
            if ((state_q == ST_BURST) && bus.fifo_empty && (remaining_q != LEN_ZERO)
                && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
        end
    end

    assign words_read   = words_read_q;
    assign stall_cycles = stall_cycles_q;
`else
    logic unused_accept_s;
    assign unused_accept_s = accept_s;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a registered-output FIFO model and an in-order scoreboard.
module tb_fifo_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_reader_if #(.FIFO_WIDTH(16), .LEN_W(8)) bus ();

`ifdef FIFO_READER_STATS_EN
    logic [15:0] words_read;
    logic [15:0] stall_cycles;
`endif

    fifo_reader #(.FIFO_WIDTH(16), .LEN_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef FIFO_READER_STATS_EN
        ,
        .words_read   (words_read),
        .stall_cycles (stall_cycles)
`endif
    );

    // Upstream FIFO model: data valid the cycle after the read strobe.
    logic [15:0] fifo_mem [0:63];
    int          fifo_wr = 0;
    int          fifo_rd = 0;
    logic        fifo_flush = 1'b0;
    assign bus.fifo_empty = (fifo_wr == fifo_rd);

    always @(posedge clk) begin
        if (fifo_flush) begin
            fifo_rd <= fifo_wr;
        end else if (bus.fifo_rd_en) begin
            bus.fifo_data_out <= fifo_mem[fifo_rd[5:0]];
            fifo_rd <= fifo_rd + 1;
        end
    end

    logic [15:0] exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc_n, rd_cnt, xfer_cnt, done_cnt, first_xfer, last_xfer, done_cyc;
    logic stab_armed = 1'b0;
    logic prev_rst   = 1'b1;
    logic [15:0] prev_data = 16'h0000;
    logic last_valid, last_busy, last_done, last_rden;
    logic [15:0] last_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_word(input logic [15:0] w);
        fifo_mem[fifo_wr] = w;
        fifo_wr++;
        exp_q.push_back(w);
    endtask

    task automatic clr();
        cyc_n = 0; rd_cnt = 0; xfer_cnt = 0; done_cnt = 0;
        first_xfer = -1; last_xfer = -1; done_cyc = -1;
    endtask

    // One cycle: inputs already set at the negedge; sample, score, then advance.
    task automatic cyc();
        #1;
        last_valid = bus.m_valid; last_busy = bus.cmd_busy; last_done = bus.cmd_done;
        last_rden  = bus.fifo_rd_en; last_data = bus.m_data;
        if (bus.fifo_rd_en) begin
            rd_cnt++;
            check_eq("rd_en_while_empty", {31'd0, bus.fifo_empty}, 32'd0);
        end
        if (stab_armed && !prev_rst) begin
            check_eq("hold_valid", {31'd0, bus.m_valid}, 32'd1);
            check_eq("hold_data", {16'd0, bus.m_data}, {16'd0, prev_data});
        end
        stab_armed = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_rst   = rst;
        if (bus.m_valid && bus.m_ready && !rst) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_word", 32'(exp_q.size()), 32'd1);
            end else begin
                check_eq("m_data_order", {16'd0, bus.m_data}, {16'd0, exp_q.pop_front()});
            end
            xfer_cnt++;
            if (first_xfer < 0) first_xfer = cyc_n;
            last_xfer = cyc_n;
        end
        if (bus.cmd_done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        cyc_n++;
        @(negedge clk);
    endtask

    task automatic start_cmd(input logic [7:0] len);
        bus.cmd_start = 1'b1;
        bus.cmd_len   = len;
        cyc();
        bus.cmd_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            cyc();
            n++;
        end
        check_eq("done_seen", 32'(done_cnt), 32'd1);
        cyc();
        check_eq("done_single", 32'(done_cnt), 32'd1);
        check_eq("busy_after_done", {31'd0, last_busy}, 32'd0);
    endtask

    initial begin
        bus.cmd_start = 1'b0;
        bus.cmd_len   = 8'd0;
        bus.m_ready   = 1'b1;
        @(negedge clk);

        // Reset values
        clr();
        cyc(); cyc(); cyc();
        check_eq("rst_busy", {31'd0, last_busy}, 32'd0);
        check_eq("rst_done", {31'd0, last_done}, 32'd0);
        check_eq("rst_rd_en", {31'd0, last_rden}, 32'd0);
        check_eq("rst_valid", {31'd0, last_valid}, 32'd0);
        check_eq("rst_data", {16'd0, last_data}, 32'd0);
        rst = 1'b0;
        cyc();

        // Five preloaded words at full throughput
        clr();
        for (int i = 1; i <= 5; i++) push_word(16'(i));
        start_cmd(8'd5);
        wait_done(40);
        check_eq("t37_xfers", 32'(xfer_cnt), 32'd5);
        check_eq("t37_first", 32'(first_xfer), 32'd3);
        check_eq("t37_last", 32'(last_xfer), 32'd7);
        check_eq("t37_done_cyc", 32'(done_cyc), 32'd9);
        check_eq("t37_reads", 32'(rd_cnt), 32'd5);
`ifdef FIFO_READER_STATS_EN
        check_eq("t37_words_read", {16'd0, words_read}, 32'd5);
`endif

        // Zero-length command
        clr();
        start_cmd(8'd0);
        wait_done(10);
        check_eq("t38_done_cyc", 32'(done_cyc), 32'd1);
        check_eq("t38_reads", 32'(rd_cnt), 32'd0);

        // FIFO empty for six burst cycles, then filled
        clr();
        start_cmd(8'd4);
        for (int i = 0; i < 6; i++) cyc();
        check_eq("t39_no_reads_empty", 32'(rd_cnt), 32'd0);
        check_eq("t39_busy", {31'd0, last_busy}, 32'd1);
        for (int i = 0; i < 4; i++) push_word(16'h0410 + 16'(i));
        wait_done(40);
        check_eq("t39_xfers", 32'(xfer_cnt), 32'd4);
        check_eq("t39_reads", 32'(rd_cnt), 32'd4);
`ifdef FIFO_READER_STATS_EN
        check_eq("t39_stall_cycles", {16'd0, stall_cycles}, 32'd6);
`endif

        // Downstream backpressure for ten cycles
        clr();
        for (int i = 0; i < 8; i++) push_word(16'h0800 + 16'(i));
        bus.m_ready = 1'b0;
        start_cmd(8'd8);
        for (int i = 0; i < 9; i++) cyc();
        check_eq("t40_reads_stalled", 32'(rd_cnt), 32'd3);
        check_eq("t40_valid", {31'd0, last_valid}, 32'd1);
        check_eq("t40_head", {16'd0, last_data}, 32'h0800);
        bus.m_ready = 1'b1;
        wait_done(60);
        check_eq("t40_xfers", 32'(xfer_cnt), 32'd8);
        check_eq("t40_reads", 32'(rd_cnt), 32'd8);

        // Reset mid-burst
        clr();
        for (int i = 0; i < 6; i++) push_word(16'h0600 + 16'(i));
        start_cmd(8'd6);
        for (int n = 0; n < 20 && xfer_cnt < 2; n++) cyc();
        check_eq("t41_two_xfers", 32'(xfer_cnt), 32'd2);
        rst = 1'b1;
        bus.m_ready = 1'b0;
        cyc();
        rst = 1'b0;
        bus.m_ready = 1'b1;
        fifo_flush = 1'b1;
        exp_q.delete();
        cyc();
        fifo_flush = 1'b0;
        check_eq("t41_valid", {31'd0, last_valid}, 32'd0);
        check_eq("t41_busy", {31'd0, last_busy}, 32'd0);
        for (int i = 0; i < 4; i++) cyc();
        check_eq("t41_no_done", 32'(done_cnt), 32'd0);
        clr();
        push_word(16'h0A0A);
        start_cmd(8'd1);
        wait_done(20);
        check_eq("t41_restart_xfers", 32'(xfer_cnt), 32'd1);

        // cmd_start re-pulsed during the burst
        clr();
        for (int i = 0; i < 3; i++) push_word(16'h0300 + 16'(i));
        start_cmd(8'd3);
        cyc();
        start_cmd(8'd2);
        wait_done(40);
        check_eq("t42_xfers", 32'(xfer_cnt), 32'd3);
        check_eq("t42_reads", 32'(rd_cnt), 32'd3);
        check_eq("t42_leftover", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter FIFO_WIDTH, default 16, SHALL set the data word width.
REQ-002 Parameter LEN_W, default 8, SHALL set the burst length field width.
REQ-003 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 cmd_start  input  1  SHALL request a read burst; sampled only in IDLE.
REQ-006 cmd_len  input  LEN_W  SHALL give the word count of the burst, captured with cmd_start.
REQ-007 cmd_busy  output  1  SHALL be high whenever state is not IDLE.
REQ-008 cmd_done  output  1  SHALL pulse high for exactly one cycle (DONE state) at burst end.
REQ-009 fifo_empty  input  1  SHALL be the upstream FIFO empty flag.
REQ-010 fifo_data_out  input  FIFO_WIDTH  SHALL be the upstream FIFO registered read data, valid the cycle after fifo_rd_en.
REQ-011 fifo_rd_en  output  1  SHALL be the upstream FIFO read strobe (combinational).
REQ-012 m_data  output  FIFO_WIDTH  SHALL be the downstream stream data (head of skid buffer).
REQ-013 m_valid  output  1  SHALL be high when the skid buffer holds at least one word.
REQ-014 m_ready  input  1  SHALL be downstream acceptance; transfer when m_valid and m_ready are both high.

Function
REQ-015 FSM states SHALL be IDLE, BURST, FLUSH, DONE.
REQ-016 IDLE -> BURST on cmd_start with cmd_len != 0; remaining loaded with cmd_len.
REQ-017 IDLE -> DONE on cmd_start with cmd_len == 0; no FIFO reads issued.
REQ-018 BURST -> FLUSH on the edge at which remaining reaches 0.
REQ-019 FLUSH -> DONE when inflight == 0 and buffer occupancy == 0; DONE -> IDLE unconditionally next cycle.
REQ-020 cmd_start outside IDLE SHALL be ignored with no effect on the active burst.
REQ-021 fifo_rd_en SHALL equal (state == BURST) and !fifo_empty and remaining != 0 and (occupancy + inflight) < 3.
REQ-022 fifo_rd_en SHALL never assert while fifo_empty is high (no underflow generation).
REQ-023 remaining SHALL decrement by 1 on every cycle fifo_rd_en is high.
REQ-024 inflight SHALL be a 1-bit register equal to the previous cycle's fifo_rd_en.
REQ-025 When inflight is high, fifo_data_out SHALL be pushed into the 3-entry skid buffer at that cycle's edge.
REQ-026 Latency: fifo_rd_en in cycle N SHALL give m_valid with that word no earlier than cycle N+2.
REQ-027 Skid buffer SHALL support simultaneous push and pop in one cycle, occupancy unchanged.
REQ-028 Words SHALL leave on m_data in exact FIFO read order; no loss, duplication or reordering.
REQ-029 With m_ready held high and FIFO non-empty, sustained throughput SHALL be one word per cycle.
REQ-030 m_data and m_valid SHALL hold stable while m_valid is high and m_ready is low.
REQ-031 Buffer pointers SHALL wrap modulo 3; occupancy SHALL never exceed 3.

Reset
REQ-032 On rst high at a clock edge: state = IDLE, remaining = 0, inflight = 0, occupancy = 0, buffer pointers = 0.
REQ-033 Reset values: cmd_busy 0, cmd_done 0, fifo_rd_en 0, m_valid 0, m_data 0.
REQ-034 Reset mid-burst SHALL discard buffered and in-flight words; no cmd_done pulse.

Configuration
REQ-035 With FIFO_READER_STATS_EN defined, outputs words_read (16 bits, increments per downstream transfer, wraps at 65535) and stall_cycles (16 bits, increments per cycle in BURST with fifo_empty high and remaining != 0, saturates at 65535) SHALL exist, both cleared by rst and by cmd_start accepted in IDLE.
REQ-036 Without FIFO_READER_STATS_EN these ports and counters SHALL be absent and all other behaviour identical.

Verification
REQ-037 FIFO preloaded 0x0001..0x0005, cmd_len=5, m_ready=1 -> m_data 0x0001..0x0005 on 5 consecutive cycles, cmd_done one cycle after FLUSH empties, cmd_busy low next cycle.
REQ-038 cmd_len=0 -> cmd_done high cycle after cmd_start, fifo_rd_en never high.
REQ-039 cmd_len=4, FIFO empty 6 cycles then filled -> no fifo_rd_en while empty; stall_cycles=6 when FIFO_READER_STATS_EN defined; 4 words delivered in order.
REQ-040 cmd_len=8, m_ready low 10 cycles -> exactly 3 reads issued, occupancy 3, m_data stable; after m_ready high all 8 words delivered in order.
REQ-041 rst high mid-burst after 2 of 6 words -> next cycle m_valid 0, cmd_busy 0, no cmd_done; new cmd_start accepted.
REQ-042 cmd_start re-pulsed during BURST with cmd_len=2 -> ignored; original burst length completes.
